// File: rtl/xosera_bus_pkg.sv
// Shared constants, widths and FSM state type for the Xosera host-bus front end.
package xosera_bus_pkg;

    localparam logic cs_ENABLED  = 1'b0;
    localparam logic cs_DISABLED = 1'b1;
    localparam logic RnW_READ    = 1'b1;
    localparam logic RnW_WRITE   = 1'b0;

    localparam int REGNUM_W  = 4;
    localparam int BUSDATA_W = 8;
    localparam int CNT_W     = 3;
    // cs_n, rd_nwr, bytesel, reg_num, data packed into one synchronizer vector
    localparam int SYNC_W    = 3 + REGNUM_W + BUSDATA_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        QUAL    = 2'd1,
        ACTIVE  = 2'd2,
        RELEASE = 2'd3
    } bus_state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/xosera_bus_if_if.sv
// Host bus pins plus register-file side signals of the bus front end.
// Handshake: no valid/ready; each accepted access yields exactly one one-cycle strobe, read data follows one cycle later.
interface xosera_bus_if_if;
    import xosera_bus_pkg::*;

    logic                 bus_cs_n_i;
    logic                 bus_rd_nwr_i;
    logic [REGNUM_W-1:0]  bus_reg_num_i;
    logic                 bus_bytesel_i;
    logic [BUSDATA_W-1:0] bus_data_i;
    logic [BUSDATA_W-1:0] rd_data_i;
    logic                 write_strobe_o;
    logic                 read_strobe_o;
    logic [REGNUM_W-1:0]  reg_num_o;
    logic                 bytesel_o;
    logic [BUSDATA_W-1:0] data_o;
    logic [BUSDATA_W-1:0] bus_data_o;
    logic                 busy_o;
    bus_state_t           state_o;

    modport slave (
        input  bus_cs_n_i, bus_rd_nwr_i, bus_reg_num_i, bus_bytesel_i, bus_data_i, rd_data_i,
        output write_strobe_o, read_strobe_o, reg_num_o, bytesel_o, data_o, bus_data_o,
        output busy_o, state_o
    );

    modport master (
        output bus_cs_n_i, bus_rd_nwr_i, bus_reg_num_i, bus_bytesel_i, bus_data_i, rd_data_i,
        input  write_strobe_o, read_strobe_o, reg_num_o, bytesel_o, data_o, bus_data_o,
        input  busy_o, state_o
    );

endinterface

// File: rtl/bus_sync_ff.sv
// Multi-stage flop synchronizer for a vector of asynchronous inputs, with per-bit reset value.
module bus_sync_ff #(
    parameter int               WIDTH     = 1,
    parameter int               STAGES    = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_sync [STAGES];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < STAGES; i++) begin
                r_sync[i] <= RESET_VAL;
            end
        end else begin
            r_sync[0] <= i_d;
            for (int i = 1; i < STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/xosera_bus_if.sv
// Xosera host-bus front end: synchronizes the async bus, deglitches cs_n and
// turns each bus access into one read or write strobe toward the register file.
module xosera_bus_if
    import xosera_bus_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEGLITCH    = 2
) (
    input  logic           clk,
    input  logic           reset_i,
    xosera_bus_if_if.slave bus
);

    localparam logic [SYNC_W-1:0] SYNC_RST = {cs_DISABLED, {(SYNC_W-1){1'b0}}};
    localparam logic [CNT_W-1:0]  DG       = CNT_W'(DEGLITCH);

    logic [SYNC_W-1:0]    w_async;
    logic [SYNC_W-1:0]    w_sync;
    logic                 w_sync_cs_n;
    logic                 w_sync_rd_nwr;
    logic                 w_sync_bytesel;
    logic [REGNUM_W-1:0]  w_sync_reg_num;
    logic [BUSDATA_W-1:0] w_sync_data;

    bus_state_t           r_state;
    bus_state_t           w_state_nx;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_nx;
    logic [CNT_W-1:0]     w_cnt_inc;
    logic                 w_accept;

    logic                 r_write_strobe;
    logic                 r_read_strobe;
    logic                 r_rd_pending;
    logic [REGNUM_W-1:0]  r_reg_num;
    logic                 r_bytesel;
    logic [BUSDATA_W-1:0] r_data;
    logic [BUSDATA_W-1:0] r_bus_data;
    logic                 r_busy;

    assign w_async = {bus.bus_cs_n_i, bus.bus_rd_nwr_i, bus.bus_bytesel_i,
                      bus.bus_reg_num_i, bus.bus_data_i};

    bus_sync_ff #(
        .WIDTH    (SYNC_W),
        .STAGES   (SYNC_STAGES),
        .RESET_VAL(SYNC_RST)
    ) u_sync (
        .i_clk(clk),
        .i_rst(reset_i),
        .i_d  (w_async),
        .o_q  (w_sync)
    );

    assign w_sync_cs_n    = w_sync[SYNC_W-1];
    assign w_sync_rd_nwr  = w_sync[SYNC_W-2];
    assign w_sync_bytesel = w_sync[SYNC_W-3];
    assign w_sync_reg_num = w_sync[BUSDATA_W +: REGNUM_W];
    assign w_sync_data    = w_sync[BUSDATA_W-1:0];

    assign w_cnt_inc = sat_inc(r_cnt);

    // cnt counts consecutive agreeing cs_n samples; the move fires when it would reach DEGLITCH
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_accept   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_sync_cs_n == cs_ENABLED) begin
                    if (DEGLITCH == 1) begin
                        w_accept   = 1'b1;
                        w_state_nx = ACTIVE;
                        w_cnt_nx   = '0;
                    end else begin
                        w_state_nx = QUAL;
                        w_cnt_nx   = CNT_W'(1);
                    end
                end
            end
            QUAL: begin
                if (w_sync_cs_n == cs_ENABLED) begin
                    if (w_cnt_inc == DG) begin
                        w_accept   = 1'b1;
                        w_state_nx = ACTIVE;
                        w_cnt_nx   = '0;
                    end else begin
                        w_cnt_nx = w_cnt_inc;
                    end
                end else begin
                    w_state_nx = IDLE;
                    w_cnt_nx   = '0;
                end
            end
            ACTIVE: begin
                if (w_sync_cs_n == cs_DISABLED) begin
                    if (DEGLITCH == 1) begin
                        w_state_nx = IDLE;
                        w_cnt_nx   = '0;
                    end else begin
                        w_state_nx = RELEASE;
                        w_cnt_nx   = CNT_W'(1);
                    end
                end
            end
            RELEASE: begin
                if (w_sync_cs_n == cs_DISABLED) begin
                    if (w_cnt_inc == DG) begin
                        w_state_nx = IDLE;
                        w_cnt_nx   = '0;
                    end else begin
                        w_cnt_nx = w_cnt_inc;
                    end
                end else begin
                    w_state_nx = ACTIVE;
                    w_cnt_nx   = '0;
                end
            end
            default: begin
                w_state_nx = IDLE;
                w_cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    // register read data arrives one cycle after the read strobe and is held until the next read
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            r_write_strobe <= 1'b0;
            r_read_strobe  <= 1'b0;
            r_rd_pending   <= 1'b0;
            r_reg_num      <= '0;
            r_bytesel      <= 1'b0;
            r_data         <= '0;
            r_bus_data     <= '0;
            r_busy         <= 1'b0;
        end else begin
            r_write_strobe <= w_accept && (w_sync_rd_nwr == RnW_WRITE);
            r_read_strobe  <= w_accept && (w_sync_rd_nwr == RnW_READ);
            r_rd_pending   <= r_read_strobe;
            r_busy         <= (w_state_nx == ACTIVE) || (w_state_nx == RELEASE);
            if (w_accept) begin
                r_reg_num <= w_sync_reg_num;
                r_bytesel <= w_sync_bytesel;
                r_data    <= w_sync_data;
            end
            if (r_rd_pending) begin
                r_bus_data <= bus.rd_data_i;
            end
        end
    end

    assign bus.write_strobe_o = r_write_strobe;
    assign bus.read_strobe_o  = r_read_strobe;
    assign bus.reg_num_o      = r_reg_num;
    assign bus.bytesel_o      = r_bytesel;
    assign bus.data_o         = r_data;
    assign bus.bus_data_o     = r_bus_data;
    assign bus.busy_o         = r_busy;
    assign bus.state_o        = r_state;

endmodule
